// File: rtl/logic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_pkg : op encodings and FSM state codes shared by logic_unit_seq
// Rev 1.0
// ---------------------------------------------------------------------------
package logic_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/logic_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_slice : combinational CHUNK-bit AND/OR/XOR/NOR
// Rev 1.0
// ---------------------------------------------------------------------------
module logic_slice
   import logic_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic [1:0]       op_i,
   output logic [CHUNK-1:0] y_o
);

   always_comb begin
      case (op_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         default: y_o = ~(a_i | b_i);
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_unit_seq : bit-serial-by-chunk logic unit, one CHUNK slice per cycle.
// Optional parity output enabled by macro LOGIC_UNIT_PARITY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module logic_unit_seq
   import logic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic             busy,
   output logic             done
`ifdef LOGIC_UNIT_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = $clog2(N) + 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [1:0]       op_q,    op_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] y_q,     y_d;
   logic             zero_q,  zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
   logic             par_q,   par_d;
`endif

   logic [CHUNK-1:0] slice_a, slice_b, slice_y;

   // Select the slice addressed by the counter from the latched operands
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt_q == CW'(i)) begin
            slice_a = a_q[i*CHUNK +: CHUNK];
            slice_b = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   logic_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a_i  (slice_a),
      .b_i  (slice_b),
      .op_i (op_q),
      .y_o  (slice_y)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      y_d     = y_q;
      zero_d  = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) begin
                  acc_d[i*CHUNK +: CHUNK] = slice_y;
               end
            end
            cnt_d = cnt_q + CW'(1);
            // Result publishes with the final slice merged in, same edge
            if (cnt_q == CW'(N-1)) begin
               state_d = ST_DONE;
               y_d     = acc_d;
               zero_d  = (acc_d == '0);
`ifdef LOGIC_UNIT_PARITY_EN
               par_d   = ^acc_d;
`endif
            end
         end
         default: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = A;
               b_d     = B;
               op_d    = op;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_AND;
         acc_q   <= '0;
         y_q     <= '0;
         zero_q  <= 1'b1;
`ifdef LOGIC_UNIT_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign Y    = y_q;
   assign zero = zero_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
`ifdef LOGIC_UNIT_PARITY_EN
   assign parity = par_q;
`endif

endmodule
`default_nettype wire
